// File: rtl/microstep_phase_sequencer_pkg.sv
// Shared types and constants for the microstep phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package microstep_phase_sequencer_pkg;

    // Sequencer FSM: one LUT pass per coil, then a scaling cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOK_A = 2'd1,
        LOOK_B = 2'd2,
        SCALE  = 2'd3
    } state_t;

    localparam int PHASE_W = 8;   // electrical phase, 256 steps per cycle
    localparam int IDX_W   = 6;   // quarter-wave LUT index
    localparam logic [2:0] MAX_SHIFT = 3'd6;  // full step = 64 phase units

    // Phase increment for a given microstep shift, clamped at a full step.
    function automatic logic [PHASE_W-1:0] phase_inc(input logic [2:0] shift);
        logic [2:0] s;
        s = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
        return {{(PHASE_W-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/microstep_phase_sequencer_cosine.sv
// Quarter-wave cosine table: o_val = round(255*cos(i_idx*pi/128)).
// Latency: combinational.
// Backpressure: none.
// Ports: i_idx (6-bit table index), o_val (8-bit unsigned magnitude).
module cosine
    import microstep_phase_sequencer_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [7:0]       o_val
);

    localparam logic [7:0] LUT [64] = '{
        8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd253, 8'd252, 8'd251,
        8'd250, 8'd249, 8'd247, 8'd246, 8'd244, 8'd242, 8'd240, 8'd238,
        8'd236, 8'd233, 8'd231, 8'd228, 8'd225, 8'd222, 8'd219, 8'd215,
        8'd212, 8'd208, 8'd205, 8'd201, 8'd197, 8'd193, 8'd189, 8'd185,
        8'd180, 8'd176, 8'd171, 8'd167, 8'd162, 8'd157, 8'd152, 8'd147,
        8'd142, 8'd136, 8'd131, 8'd126, 8'd120, 8'd115, 8'd109, 8'd103,
        8'd98,  8'd92,  8'd86,  8'd80,  8'd74,  8'd68,  8'd62,  8'd56,
        8'd50,  8'd44,  8'd37,  8'd31,  8'd25,  8'd19,  8'd13,  8'd6
    };

    assign o_val = LUT[i_idx];

endmodule

// File: rtl/microstep_phase_sequencer.sv
// Two-phase stepper microstep sequencer: phase accumulator, quadrant fold, shared cosine LUT, current scaling.
// Latency: step sampled in IDLE (cycle 0) -> valid strobe with new magnitudes in cycle 4.
// Backpressure: none; one step is buffered while busy, a further step is dropped and sets sticky overrun.
module microstep_phase_sequencer
    import microstep_phase_sequencer_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES = 24'd1_000_000
)
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       step,
    input  logic       dir,
    input  logic [2:0] step_shift,
    input  logic [7:0] current,
`ifdef MICROSTEP_HOLD_EN
    input  logic [7:0] hold_current,
`endif
    output logic [7:0] a_mag,
    output logic [7:0] b_mag,
    output logic       a_neg,
    output logic       b_neg,
    output logic       valid,
    output logic       busy,
    output logic       overrun
);

    state_t             r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_phase, w_phase_nxt;
    logic               r_pending, r_pend_dir;
    logic [2:0]         r_pend_shift;
    logic [7:0]         r_a_raw, r_b_raw, r_a_mag, r_b_mag;
    logic               r_a_neg, r_b_neg, r_valid, r_overrun;

    logic               w_req, w_start, w_hold_go, w_use_dir, w_busy;
    logic [2:0]         w_use_shift;
    logic [IDX_W-1:0]   w_i, w_idx_a, w_idx_b, w_lut_idx;
    logic [7:0]         w_lut_val, w_scale, w_a_scaled, w_b_scaled;

    // A buffered request is always older than a live one, so it is served first.
    assign w_req       = step | r_pending;
    assign w_use_dir   = r_pending ? r_pend_dir   : dir;
    assign w_use_shift = r_pending ? r_pend_shift : step_shift;
    assign w_phase_nxt = w_use_dir ? (r_phase + phase_inc(w_use_shift))
                                   : (r_phase - phase_inc(w_use_shift));

    // Quadrant fold: odd quadrants mirror the index. Coil B follows cosine,
    // coil A follows sine, i.e. the mirrored index of coil B.
    assign w_i     = r_phase[IDX_W-1:0];
    assign w_idx_b = r_phase[PHASE_W-2] ? ~w_i : w_i;
    assign w_idx_a = r_phase[PHASE_W-2] ? w_i  : ~w_i;

    cosine u_cosine (
        .i_idx (w_lut_idx),
        .o_val (w_lut_val)
    );

`ifdef MICROSTEP_HOLD_EN
    logic [23:0] r_idle_cnt;
    logic        r_holding, r_hold_seq;

    // Hold sequence fires once per idle stretch; a step re-arms it.
    assign w_hold_go = (r_state == IDLE) && !w_req && !r_holding && (r_idle_cnt == HOLD_CYCLES);
    assign w_scale   = r_hold_seq ? hold_current : current;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
            r_holding  <= 1'b0;
            r_hold_seq <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_req) begin
                r_idle_cnt <= '0;
                r_holding  <= 1'b0;
                r_hold_seq <= 1'b0;
            end else if (w_hold_go) begin
                r_hold_seq <= 1'b1;
            end else if (r_idle_cnt != HOLD_CYCLES) begin
                r_idle_cnt <= r_idle_cnt + 24'd1;
            end
        end else if (r_state == SCALE && r_hold_seq) begin
            r_holding  <= 1'b1;
            r_hold_seq <= 1'b0;
        end
    end
`else
    assign w_hold_go = 1'b0;
    assign w_scale   = current;
`endif

    assign w_start = w_req | w_hold_go;

    // Upper byte of the 16-bit product.
    assign w_a_scaled = 8'((16'(r_a_raw) * 16'(w_scale)) >> 8);
    assign w_b_scaled = 8'((16'(r_b_raw) * 16'(w_scale)) >> 8);

    // FSM state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = LOOK_A;
            LOOK_A:  w_state_nxt = LOOK_B;
            LOOK_B:  w_state_nxt = SCALE;
            SCALE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and LUT index mux
    always_comb begin
        w_busy    = 1'b0;
        w_lut_idx = w_idx_b;
        case (r_state)
            LOOK_A: begin
                w_busy    = 1'b1;
                w_lut_idx = w_idx_a;
            end
            LOOK_B, SCALE: w_busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_phase      <= '0;
            r_pending    <= 1'b0;
            r_pend_dir   <= 1'b0;
            r_pend_shift <= 3'd0;
            r_a_raw      <= 8'd0;
            r_b_raw      <= 8'd0;
            r_a_mag      <= 8'd0;
            r_b_mag      <= 8'd0;
            r_a_neg      <= 1'b0;
            r_b_neg      <= 1'b0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_phase <= w_phase_nxt;
                        // Pending served now; a simultaneous live step takes its slot.
                        r_pending <= r_pending & step;
                        if (r_pending && step) begin
                            r_pend_dir   <= dir;
                            r_pend_shift <= step_shift;
                        end
                    end
                end
                LOOK_A: r_a_raw <= w_lut_val;
                LOOK_B: r_b_raw <= w_lut_val;
                SCALE: begin
                    r_a_mag <= w_a_scaled;
                    r_b_mag <= w_b_scaled;
                    r_a_neg <= r_phase[PHASE_W-1];
                    r_b_neg <= r_phase[PHASE_W-1] ^ r_phase[PHASE_W-2];
                    r_valid <= 1'b1;
                end
                default: ;
            endcase

            if (r_state != IDLE && step) begin
                if (!r_pending) begin
                    r_pending    <= 1'b1;
                    r_pend_dir   <= dir;
                    r_pend_shift <= step_shift;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign a_mag   = r_a_mag;
    assign b_mag   = r_b_mag;
    assign a_neg   = r_a_neg;
    assign b_neg   = r_b_neg;
    assign valid   = r_valid;
    assign busy    = w_busy;
    assign overrun = r_overrun;

endmodule
